roi_shift_ctrl: RTL and testbench

- Sequencer for the single-bit strobe-gated ROI register (clk, stb, di → do) used in the tilegrid fuzzer designs.
- Accepts a parallel word on a valid/ready input and serialises it LSB-first into the ROI, one strobe per bit.
- Captures each bit returned on the ROI output and presents the reassembled word on a valid/ready output.
- Also reports a per-word mismatch flag, so the ROI path can be exercised end-to-end in hardware.

---
 rtl/roi_ctrl_pkg.sv | 6 +
 rtl/roi_stb_timer.sv | 23 ++
 rtl/roi_shift_ctrl.sv | 94 +++++++++
 tb/tb_roi_shift_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/roi_ctrl_pkg.sv
// roi_ctrl_pkg: shared FSM state type and parameter limits for the ROI shift controller
package roi_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} roi_ctrl_state_e;
  localparam int WIDTH_MAX = 64;
  localparam int STB_DIV_MAX = 255;
endpackage

// File: rtl/roi_stb_timer.sv
// roi_stb_timer: strobe divider; stb_tick fires every STB_DIV cycles while run is high
//   clk, rst_n : clock, async active-low reset
//   start      : rewind the divider so the first tick is immediate
//   run        : enable counting / ticking
//   stb_tick   : one-cycle pulse, strobe due this cycle
module roi_stb_timer import roi_ctrl_pkg::*; #(
  parameter int STB_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic stb_tick
);
  localparam int DIV = STB_DIV > STB_DIV_MAX ? STB_DIV_MAX : STB_DIV;
  logic [7:0] div_cnt;
  assign stb_tick = run && div_cnt == 8'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_cnt <= '0;
    else if (start) div_cnt <= '0;
    else if (stb_tick) div_cnt <= 8'(DIV - 1);
    else if (run) div_cnt <= div_cnt - 8'd1;
endmodule

// File: rtl/roi_shift_ctrl.sv
// roi_shift_ctrl: serialises a word LSB-first into the strobe-gated ROI and reassembles its echo
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_data      : word to send
//   out_valid/out_ready/out_data   : reassembled word from roi_do
//   out_err                        : some echoed bit differed from the bit sent
//   stb, di                        : registered strobe and serial data to the ROI
//   roi_do                         : ROI registered output
module roi_shift_ctrl import roi_ctrl_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int STB_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             stb,
  output logic             di,
  input  logic             roi_do
);
  localparam int BW = $clog2(WIDTH + 1);
  roi_ctrl_state_e state, state_nxt;
  logic [WIDTH-1:0] tx_sr, rx_sr, rx_nxt;
  logic [WIDTH:0] rx_cat;
  logic [BW-1:0] bit_cnt;
  logic cap_q, chk_q, err, accept, tick, last, bad;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  // bit_cnt reaching WIDTH stops the timer, so nothing counts past its terminal value
  assign last      = bit_cnt == BW'(WIDTH);
  assign rx_cat    = {roi_do, rx_sr};
  assign rx_nxt    = rx_cat[WIDTH:1];
  // chk_q is di one cycle late, i.e. the bit whose echo is on roi_do when cap_q is set
  assign bad       = cap_q && roi_do != chk_q;
  roi_stb_timer #(.STB_DIV(STB_DIV)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept),
    .run(state == SHIFT && !last),
    .stb_tick(tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = accept ? SHIFT : IDLE;
      SHIFT: state_nxt = last ? DRAIN : SHIFT;
      DRAIN: state_nxt = DONE;
      DONE:  state_nxt = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stb      <= 1'b0;
      di       <= 1'b0;
      cap_q    <= 1'b0;
      chk_q    <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      err      <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      stb   <= tick;
      cap_q <= stb;
      chk_q <= di;
      if (accept) begin
        tx_sr   <= in_data;
        bit_cnt <= '0;
        err     <= 1'b0;
      end else if (tick) begin
        di      <= tx_sr[0];
        tx_sr   <= tx_sr >> 1;
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (cap_q) begin
        rx_sr <= rx_nxt;
        err   <= err | bad;
      end
      // DRAIN always coincides with the final capture, so publish the merged values
      if (state == DRAIN) begin
        out_data <= rx_nxt;
        out_err  <= err | bad;
      end
    end
endmodule

// File: tb/tb_roi_shift_ctrl.sv
// tb_roi_shift_ctrl: three controller configurations, each driving a behavioural ROI with fault injection
module tb_roi_shift_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic [2:0] iv = 0, ordy = 0, roi_v = 0;
  logic [2:0] ir, ov, oe, stb_v, di_v;
  logic [15:0] din = 0;
  logic [15:0] d0;
  logic [7:0] d1;
  logic [0:0] d2;
  int scnt[3] = '{0, 0, 0};
  int base[3] = '{0, 0, 0};
  int fbit[3] = '{-1, -1, -1};
  int ntest = 0, nfail = 0;
  roi_shift_ctrl #(.WIDTH(16), .STB_DIV(1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(din), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(d0), .out_err(oe[0]),
    .stb(stb_v[0]), .di(di_v[0]), .roi_do(roi_v[0]));
  roi_shift_ctrl #(.WIDTH(8), .STB_DIV(3)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(din[7:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(d1), .out_err(oe[1]),
    .stb(stb_v[1]), .di(di_v[1]), .roi_do(roi_v[1]));
  roi_shift_ctrl #(.WIDTH(1), .STB_DIV(1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(din[0:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(d2), .out_err(oe[2]),
    .stb(stb_v[2]), .di(di_v[2]), .roi_do(roi_v[2]));
  // ROI: captures di on each strobe, optionally inverting the fbit-th bit of the current word
  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (stb_v[k]) begin
        roi_v[k] <= di_v[k] ^ (scnt[k] - base[k] == fbit[k]);
        scnt[k] <= scnt[k] + 1;
      end
  function automatic logic [15:0] dout(input int k);
    return k == 0 ? d0 : k == 1 ? {8'h0, d1} : {15'h0, d2};
  endfunction
  task automatic run_word(input int k, input int w, input int d, input logic [15:0] data, input int fb,
                          input int hold, input logic nv, input logic [15:0] ndata);
    int sc[$];
    logic sd[$];
    int vc;
    logic [15:0] exp, od;
    logic oerr, eerr;
    exp = data ^ (fb >= 0 ? 16'(1) << fb : 16'h0);
    eerr = fb >= 0;
    for (int i = 0; i < 50 && !ir[k]; i++) @(negedge clk);
    ntest++;
    if (ir[k] !== 1'b1) begin nfail++; $display("FAIL ready_wait dut%0d in_ready=%b want 1", k, ir[k]); end
    fbit[k] = fb;
    base[k] = scnt[k];
    din = data;
    iv[k] = 1;
    @(posedge clk);
    vc = -1;
    for (int c = 0; c < 3 + (w - 1) * d + 6; c++) begin
      @(negedge clk);
      if (c == 0) iv[k] = 0;
      if (stb_v[k]) begin sc.push_back(c); sd.push_back(di_v[k]); end
      if (ov[k]) begin vc = c; break; end
    end
    ntest++;
    if (sc.size() != w) begin nfail++; $display("FAIL stb_count dut%0d got %0d want %0d", k, sc.size(), w); end
    for (int i = 0; i < sc.size() && i < w; i++) begin
      ntest++;
      if (sc[i] != 1 + i * d || sd[i] !== data[i]) begin
        nfail++;
        $display("FAIL stb_bit dut%0d #%0d cycle %0d di %b want cycle %0d di %b", k, i, sc[i], sd[i], 1 + i * d, data[i]);
      end
    end
    ntest++;
    if (vc != 3 + (w - 1) * d) begin nfail++; $display("FAIL latency dut%0d out_valid cycle %0d want %0d", k, vc, 3 + (w - 1) * d); end
    od = dout(k);
    oerr = oe[k];
    ntest++;
    if (od !== exp) begin nfail++; $display("FAIL out_data dut%0d got %h want %h", k, od, exp); end
    ntest++;
    if (oerr !== eerr) begin nfail++; $display("FAIL out_err dut%0d got %b want %b", k, oerr, eerr); end
    for (int h = 0; h < hold; h++) begin
      if (nv) begin din = ndata; iv[k] = 1; end
      @(negedge clk);
      ntest++;
      if (ov[k] !== 1'b1 || dout(k) !== od || oe[k] !== oerr || ir[k] !== 1'b0) begin
        nfail++;
        $display("FAIL hold dut%0d cyc %0d valid %b data %h err %b ready %b want 1 %h %b 0", k, h, ov[k], dout(k), oe[k], ir[k], od, oerr);
      end
    end
    ordy[k] = 1;
    @(posedge clk);
    @(negedge clk);
    ordy[k] = 0;
    ntest++;
    if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
      nfail++;
      $display("FAIL release dut%0d out_valid %b in_ready %b want 0 1", k, ov[k], ir[k]);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    ntest++;
    if (stb_v !== 3'b000 || di_v !== 3'b000 || ir !== 3'b111 || ov !== 3'b000 || oe !== 3'b000 || d0 !== 16'h0) begin
      nfail++;
      $display("FAIL reset_state stb %b di %b ready %b valid %b err %b data %h", stb_v, di_v, ir, ov, oe, d0);
    end
    rst_n = 1;
    @(negedge clk);
    ntest++;
    if (stb_v !== 3'b000 || ir !== 3'b111 || ov !== 3'b000) begin
      nfail++;
      $display("FAIL post_reset stb %b ready %b valid %b want 000 111 000", stb_v, ir, ov);
    end
  endtask
  task automatic test_default();
    run_word(0, 16, 1, 16'hA5C3, -1, 0, 0, 0);
  endtask
  task automatic test_div3();
    run_word(1, 8, 3, 16'h0081, -1, 0, 0, 0);
  endtask
  task automatic test_fault();
    run_word(0, 16, 1, 16'h0000, 5, 0, 0, 0);
    run_word(0, 16, 1, 16'hFFFF, -1, 0, 0, 0);
  endtask
  task automatic test_backpressure();
    run_word(0, 16, 1, 16'h3C5A, -1, 10, 1, 16'h1234);
    run_word(0, 16, 1, 16'h1234, -1, 0, 0, 0);
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    din = 16'hBEEF;
    iv[0] = 1;
    @(posedge clk);
    #1 iv[0] = 0;
    repeat (7) @(posedge clk);
    #1 rst_n = 0;
    #1;
    ntest++;
    if (stb_v !== 3'b000 || di_v[0] !== 1'b0 || ir !== 3'b111 || ov !== 3'b000) begin
      nfail++;
      $display("FAIL reset_mid stb %b di %b ready %b valid %b want 000 0 111 000", stb_v, di_v[0], ir, ov);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ntest++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || d0 !== 16'h0 || oe[0] !== 1'b0) begin
      nfail++;
      $display("FAIL reset_release ready %b valid %b data %h err %b want 1 0 0000 0", ir[0], ov[0], d0, oe[0]);
    end
    run_word(0, 16, 1, 16'h6D2B, -1, 0, 0, 0);
  endtask
  task automatic test_width1();
    run_word(2, 1, 1, 16'h0001, -1, 0, 0, 0);
    run_word(2, 1, 1, 16'h0000, 0, 1, 0, 0);
  endtask
  task automatic test_random();
    int k, w, d, fb;
    logic [15:0] m, data;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 2);
      w = k == 0 ? 16 : k == 1 ? 8 : 1;
      d = k == 1 ? 3 : 1;
      m = k == 0 ? 16'hFFFF : k == 1 ? 16'h00FF : 16'h0001;
      data = 16'($urandom) & m;
      fb = $urandom_range(0, 1) != 0 ? -1 : int'($urandom_range(0, w - 1));
      run_word(k, w, d, data, fb, int'($urandom_range(0, 3)), 0, 0);
    end
  endtask
  initial begin
    test_reset();
    test_default();
    test_div3();
    test_fault();
    test_backpressure();
    test_reset_mid();
    test_width1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
